// File: rtl/seg7_scan_decoder.sv
// Reader side of a multiplexed 7-segment display bus.
// Synchronizes the segment and digit-select lines, waits for each digit to
// settle, decodes it back to BCD and publishes one coherent frame per scan.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_SYNC    | waiting for a digit-0 capture to start a frame
// ST_COLLECT | gathering digits into the shadow slots; publish once all are in
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int DISPLAY_TYPE  = 0,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [7:0]              seg7_i,
    input  logic [NUM_DIGITS-1:0]   digit_sel_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic [NUM_DIGITS-1:0]   invalid_o,
    output logic                    frame_valid_o,
    output logic                    error_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] MASK_D0 = NUM_DIGITS'(1);

    typedef enum logic {ST_SYNC, ST_COLLECT} state_t;

    // Decimal point carries no digit information.
    logic dp_unused;
    assign dp_unused = seg7_i[7];

    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] sel_s1, sel_s2;

    // Two-flop synchronizers on the segment and select lines.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            sel_s1 <= '0;
            sel_s2 <= '0;
        end else begin
            seg_s1 <= seg7_i[6:0];
            seg_s2 <= seg_s1;
            sel_s1 <= digit_sel_i;
            sel_s2 <= sel_s1;
        end
    end

    // The newest synchronized sample is compared with the one before it, so
    // a digit is accepted exactly SETTLE_CYCLES samples after it first lands.
    logic       sel_onehot, pair_same, armed, capture;
    logic [7:0] stable_cnt, cnt_next;

    assign sel_onehot = (sel_s1 != '0) && ((sel_s1 & (sel_s1 - MASK_D0)) == '0);
    assign pair_same  = (sel_s1 == sel_s2) && (seg_s1 == seg_s2);

    // Saturating stable counter; any change or non-one-hot select clears it.
    always_comb begin
        cnt_next = '0;
        if (pair_same && sel_onehot)
            cnt_next = (stable_cnt == SETTLE) ? stable_cnt : stable_cnt + 8'd1;
    end

    assign capture = armed && (cnt_next == SETTLE) && (stable_cnt != SETTLE);

    // Counter register and one-capture-per-activation arm flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            stable_cnt <= cnt_next;
            if (capture)
                armed <= 1'b0;
            else if (sel_s1 != sel_s2)
                armed <= 1'b1;
        end
    end

    // Returns {invalid, blank, bcd} for a normalized g..a pattern.
    function automatic logic [5:0] decode7(input logic [6:0] p);
        case (p)
            7'b0111111: decode7 = {2'b00, 4'd0};
            7'b0000110: decode7 = {2'b00, 4'd1};
            7'b1011011: decode7 = {2'b00, 4'd2};
            7'b1001111: decode7 = {2'b00, 4'd3};
            7'b1100110: decode7 = {2'b00, 4'd4};
            7'b1101101: decode7 = {2'b00, 4'd5};
            7'b1111101: decode7 = {2'b00, 4'd6};
            7'b0000111: decode7 = {2'b00, 4'd7};
            7'b1111111: decode7 = {2'b00, 4'd8};
            7'b1101111: decode7 = {2'b00, 4'd9};
            7'b0000000: decode7 = {2'b01, 4'd0};
            default:    decode7 = {2'b10, 4'hF};
        endcase
    endfunction

    logic [6:0]       seg_norm;
    logic [3:0]       dec_bcd;
    logic             dec_blank, dec_inv;
    logic [IDX_W-1:0] cap_idx;

    assign seg_norm = (DISPLAY_TYPE == 1) ? ~seg_s2 : seg_s2;
    assign {dec_inv, dec_blank, dec_bcd} = decode7(seg_norm);

    // One-hot select to digit index; only meaningful while capture is high.
    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (sel_s2[i]) cap_idx = IDX_W'(i);
    end

    logic [4*NUM_DIGITS-1:0] sh_bcd;
    logic [NUM_DIGITS-1:0]   sh_blank, sh_inv;

    // Every capture refreshes its slot; a published frame only ever contains
    // slots written during that frame, so stale writes are harmless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_bcd   <= '0;
            sh_blank <= '0;
            sh_inv   <= '0;
        end else if (capture) begin
            sh_bcd[4*int'(cap_idx) +: 4] <= dec_bcd;
            sh_blank[cap_idx]            <= dec_blank;
            sh_inv[cap_idx]              <= dec_inv;
        end
    end

    state_t                state;
    logic [NUM_DIGITS-1:0] mask;

    // Frame assembly and atomic publish of the shadow slots.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_SYNC;
            mask          <= '0;
            bcd_o         <= '0;
            blank_o       <= '0;
            invalid_o     <= '0;
            frame_valid_o <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            frame_valid_o <= 1'b0;
            error_o       <= 1'b0;
            case (state)
                ST_SYNC: begin
                    if (capture && cap_idx == '0) begin
                        mask  <= MASK_D0;
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (&mask) begin
                        bcd_o         <= sh_bcd;
                        blank_o       <= sh_blank;
                        invalid_o     <= sh_inv;
                        frame_valid_o <= 1'b1;
                        error_o       <= |sh_inv;
                        mask          <= '0;
                        state         <= ST_SYNC;
                    end else if (capture) begin
                        if (mask[cap_idx]) begin
                            if (cap_idx == '0) begin
                                mask <= MASK_D0;
                            end else begin
                                mask  <= '0;
                                state <= ST_SYNC;
                            end
                        end else begin
                            mask[cap_idx] <= 1'b1;
                        end
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Reader side of the multiplexed 7-segment display bus. Samples the segment lines and one-hot digit-select lines of a scanned multi-digit display and decodes each settled segment pattern back to BCD, including blank (ripple-blanked) digits. Publishes one coherent decoded frame per complete scan. Used for display loop-back checking and for capturing an external display's readout.

Parameters:
NUM_DIGITS, 4, number of scanned digits (select width); 2..8
DISPLAY_TYPE, 0, 0 = common cathode (segments active-high); 1 = common anode (segment inputs inverted before decode)
SETTLE_CYCLES, 4, consecutive stable synchronized cycles required before a digit is captured; 1..255

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
seg7_i  input  8  segment bus: bit0..6 = segments a..g, bit7 = dp (dp ignored)
digit_sel_i  input  NUM_DIGITS  digit select, active-high; bit k = digit k
bcd_o  output  4*NUM_DIGITS  decoded digits; nibble k = digit k
blank_o  output  NUM_DIGITS  bit k = 1: digit k was blank (all segments off)
invalid_o  output  NUM_DIGITS  bit k = 1: digit k pattern not decodable
frame_valid_o  output  1  one-cycle pulse when bcd_o/blank_o/invalid_o update
error_o  output  1  one-cycle pulse, coincident with frame_valid_o, when any invalid_o bit is set in the new frame

Behaviour:
- Reset: interface is one clock, asynchronous active-low reset rst_ni. While rst_ni = 0, all outputs are 0, synchronizers are 0, stable counter is 0, capture mask is 0, and the FSM is in SYNC. Reset mid-frame discards the partial frame; outputs keep 0 until the first complete frame.
- Input path: seg7_i and digit_sel_i pass through 2-flop synchronizers. Both FSM paths operate on synchronized values only.
- Normalize: if DISPLAY_TYPE = 1, invert seg bits 0..6. Decode bits 6..0.
- Decode table (g..a): 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9.
  - 0000000 gives bcd 0, blank 1.
  - Any other pattern gives bcd 4'hF, invalid 1.
- Stability:
  - If the synchronized (sel, seg) pair equals its value from the previous cycle and sel is exactly one-hot, stable_cnt increments, saturating at SETTLE_CYCLES.
  - Otherwise stable_cnt is 0.
  - A non-one-hot sel (all-zero or multi-hot ghost gap) never captures and does not abort a frame.
- Capture: fires on the cycle in which stable_cnt reaches SETTLE_CYCLES, once per select activation. An armed flag clears on capture and re-arms on any sel change.
- Timing: pins change before edge N and then hold. Capture registers at edge N+1+SETTLE_CYCLES. If that capture completes the frame, the outputs and the pulse are visible after edge N+2+SETTLE_CYCLES.
- Capture stores digit k's decode into shadow slot k and sets mask[k].
- FSM:
  - SYNC: ignore captures of digits other than 0. A capture of digit 0 stores the slot, sets mask = 1, and moves to COLLECT.
  - COLLECT, capture of digit k with mask[k] = 0: store the slot and set mask[k].
  - COLLECT, capture of digit k with mask[k] = 1 (repeat before completion, i.e. scan restart or glitch): discard the partial frame. If k = 0, restart with mask = 1 and stay in COLLECT. Otherwise clear mask and go to SYNC.
  - COLLECT, mask all ones: on the next cycle, copy all shadow slots to bcd_o/blank_o/invalid_o atomically. Pulse frame_valid_o (and error_o if any invalid) for 1 cycle, clear mask, go to SYNC.
- Scan order within a frame is free; a frame is digits 0..NUM_DIGITS-1 each captured exactly once, starting with digit 0.
- Outputs are held between frames.
- The last-captured digit completing a frame and a new digit-0 capture can never occur in the same cycle, because capture needs at least SETTLE_CYCLES ≥ 1 stable cycles after a sel change.

Test Plan:
- Reset, then scan "1234" (sel 0001→0010→0100→1000, segs 06/5B/4F/66), each held 10 cycles, SETTLE_CYCLES = 4 → frame_valid_o pulses once; bcd_o = 16'h4321; blank_o = 0; invalid_o = 0; error_o = 0.
- Scan "  07" with leading blanks (digit3/2 seg 00, digit1 3F, digit0 07) → bcd_o = 16'h0007, blank_o = 4'b1100.
- Digit 2 pattern 7F replaced by 49 → nibble 2 = F, invalid_o = 4'b0100, error_o pulses with frame_valid_o.
- Hold each digit only 3 synced cycles with SETTLE_CYCLES = 4 → no capture, no frame_valid_o, outputs unchanged. Toggle seg mid-hold → counter restarts.
- Sequence 0001, 0010, 0001, 0010, 0100, 1000 → first partial discarded; exactly one frame_valid_o, after the 1000 capture.
- DISPLAY_TYPE = 1, inverted segs for "9050" → bcd_o = 16'h9050. Assert rst_ni low mid-scan → all outputs 0 immediately, next frame requires a fresh digit-0 capture.
